// File: rtl/alu_operand_loader.sv
// alu_operand_loader: debounced, key-stepped entry of {op, a, b} for the 3-bit ALU.
// The operator sets the switches for one field at a time and latches it with the
// step key. The clear key abandons the entry. Opcodes 5..7 are refused at entry.

// key_debouncer: synchronizes one raw active-low key and emits a single-cycle
// pulse when a debounced press (1->0) is accepted. Releases are filtered the
// same way but produce no pulse.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   synced;
    logic                   level;
    logic [CW-1:0]          count;

    assign synced = sync_chain[SYNC_STAGES-1];

    // Shift the raw key through the synchronizer; reset state reads as released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_chain <= '1;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], key_raw_n};
        end
    end

    // Accept a level change only after it has held for the full debounce window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= 1'b1;
            count <= '0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (synced == level) begin
                count <= '0;
            end else if (count == CW'(DEBOUNCE_CYCLES)) begin
                level <= ~level;
                count <= '0;
                press <= level;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

module alu_operand_loader #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] sw_data,
    input  logic       key_step_n,
    input  logic       key_clear_n,
    output logic [8:0] alu_word,
    output logic       word_valid,
    output logic       word_load,
    output logic [1:0] stage,
    output logic       op_reject
);

    typedef enum logic [1:0] {
        LOAD_OP = 2'b00,
        LOAD_A  = 2'b01,
        LOAD_B  = 2'b10,
        READY   = 2'b11
    } stage_t;

    stage_t     state;
    logic [2:0] op_reg;
    logic [2:0] a_reg;
    logic [2:0] b_reg;
    logic       step_evt;
    logic       clear_evt;

    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_step_key (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_raw_n (key_step_n),
        .press     (step_evt)
    );

    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_clear_key (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_raw_n (key_clear_n),
        .press     (clear_evt)
    );

    assign alu_word = {op_reg, a_reg, b_reg};
    assign stage    = state;

    // Entry sequencer: clear always beats step; fields stay put until rewritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOAD_OP;
            op_reg     <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            word_valid <= 1'b0;
            word_load  <= 1'b0;
            op_reject  <= 1'b0;
        end else begin
            word_load <= 1'b0;
            op_reject <= 1'b0;
            if (clear_evt) begin
                state      <= LOAD_OP;
                op_reg     <= '0;
                a_reg      <= '0;
                b_reg      <= '0;
                word_valid <= 1'b0;
            end else if (step_evt) begin
                case (state)
                    LOAD_OP: begin
                        if (sw_data <= 3'd4) begin
                            op_reg <= sw_data;
                            state  <= LOAD_A;
                        end else begin
                            op_reject <= 1'b1;
                        end
                    end
                    LOAD_A: begin
                        a_reg <= sw_data;
                        state <= LOAD_B;
                    end
                    LOAD_B: begin
                        b_reg      <= sw_data;
                        state      <= READY;
                        word_valid <= 1'b1;
                        word_load  <= 1'b1;
                    end
                    default: begin
                        state      <= LOAD_OP;
                        word_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_loader.sv
// tb_alu_operand_loader: directed entry sequences against a behavioural model of
// the loader, plus hand-computed expectations for the key scenarios.
module tb_alu_operand_loader;

    localparam int DB  = 4;
    localparam int SS  = 2;
    localparam int HN  = SS + DB;

    logic       clk;
    logic       rst_n;
    logic [2:0] sw_data;
    logic       key_step_n;
    logic       key_clear_n;
    logic [8:0] alu_word;
    logic       word_valid;
    logic       word_load;
    logic [1:0] stage;
    logic       op_reject;

    int checks_total  = 0;
    int checks_passed = 0;
    int load_count    = 0;
    int reject_count  = 0;
    bit run_done      = 0;

    alu_operand_loader #(
        .DEBOUNCE_CYCLES (DB),
        .SYNC_STAGES     (SS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw_data     (sw_data),
        .key_step_n  (key_step_n),
        .key_clear_n (key_clear_n),
        .alu_word    (alu_word),
        .word_valid  (word_valid),
        .word_load   (word_load),
        .stage       (stage),
        .op_reject   (op_reject)
    );

    // Free-running 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model state: raw key history (bit 0 newest), accepted levels,
    // pending press events and the entry fields.
    logic [HN-1:0] m_step_hist;
    logic [HN-1:0] m_clear_hist;
    logic          m_step_level;
    logic          m_clear_level;
    logic          m_step_evt;
    logic          m_clear_evt;
    int            m_stage;
    logic [2:0]    m_op;
    logic [2:0]    m_a;
    logic [2:0]    m_b;
    logic          m_valid;
    logic          m_load;
    logic          m_reject;

    // A key level is accepted once the synchronized view (SS samples old) has
    // disagreed with the accepted level for DB+1 consecutive samples.
    function automatic logic window_flips(input logic [HN-1:0] hist, input logic lvl);
        logic [DB:0] win;
        win = hist[SS-1 +: DB+1];
        return lvl ? (win == '0) : (win == '1);
    endfunction

    // Model update at each active edge; asynchronous reset clears everything.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_step_hist   = '1;
            m_clear_hist  = '1;
            m_step_level  = 1'b1;
            m_clear_level = 1'b1;
            m_step_evt    = 1'b0;
            m_clear_evt   = 1'b0;
            m_stage       = 0;
            m_op          = 3'd0;
            m_a           = 3'd0;
            m_b           = 3'd0;
            m_valid       = 1'b0;
            m_load        = 1'b0;
            m_reject      = 1'b0;
        end else begin
            m_load   = 1'b0;
            m_reject = 1'b0;
            if (m_clear_evt) begin
                m_stage = 0;
                m_op = 3'd0; m_a = 3'd0; m_b = 3'd0;
                m_valid = 1'b0;
            end else if (m_step_evt) begin
                if (m_stage == 0) begin
                    if (sw_data > 3'd4) m_reject = 1'b1;
                    else begin m_op = sw_data; m_stage = 1; end
                end else if (m_stage == 1) begin
                    m_a = sw_data; m_stage = 2;
                end else if (m_stage == 2) begin
                    m_b = sw_data; m_stage = 3; m_valid = 1'b1; m_load = 1'b1;
                end else begin
                    m_stage = 0; m_valid = 1'b0;
                end
            end
            m_step_evt  = 1'b0;
            m_clear_evt = 1'b0;
            if (window_flips(m_step_hist, m_step_level)) begin
                m_step_level = ~m_step_level;
                m_step_evt   = ~m_step_level;
            end
            if (window_flips(m_clear_hist, m_clear_level)) begin
                m_clear_level = ~m_clear_level;
                m_clear_evt   = ~m_clear_level;
            end
            m_step_hist  = {m_step_hist[HN-2:0], key_step_n};
            m_clear_hist = {m_clear_hist[HN-2:0], key_clear_n};
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual !== expected)
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        else
            checks_passed++;
    endtask

    task automatic checkRange(input string name, input int actual, input int lo, input int hi);
        checks_total++;
        if (actual < lo || actual > hi)
            $display("[TB] FAIL %s actual=%0d required=%0d..%0d", name, actual, lo, hi);
        else
            checks_passed++;
    endtask

    // Per-cycle comparison of every output against the model, away from the edge.
    always @(negedge clk) begin
        if (!run_done) begin
            checkOutput("cycle_outputs",
                        {17'd0, stage, alu_word, word_valid, word_load, op_reject},
                        {17'd0, m_stage[1:0], m_op, m_a, m_b, m_valid, m_load, m_reject});
            load_count   += int'(word_load);
            reject_count += int'(op_reject);
        end
    end

    // Set the switches, hold the chosen keys down, release and let them settle.
    task automatic applyStimulus(input logic [2:0] sw, input logic step, input logic clr, input int hold);
        @(negedge clk);
        sw_data     = sw;
        key_step_n  = ~step;
        key_clear_n = ~clr;
        repeat (hold) @(negedge clk);
        key_step_n  = 1'b1;
        key_clear_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    // Global time limit
    initial begin
        #200us;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        int load0;
        int rej0;
        int n;

        sw_data     = 3'd0;
        key_step_n  = 1'b1;
        key_clear_n = 1'b1;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_word", 32'(alu_word), 32'd0);
        checkOutput("reset_stage", 32'(stage), 32'd0);
        checkOutput("reset_flags", {29'd0, word_valid, word_load, op_reject}, 32'd0);
        rst_n = 1'b1;

        // Entry of a full word
        load0 = load_count;
        applyStimulus(3'd3, 1'b1, 1'b0, 12);
        checkOutput("entry_stage_a", 32'(stage), 32'd1);
        applyStimulus(3'd2, 1'b1, 1'b0, 12);
        checkOutput("entry_stage_b", 32'(stage), 32'd2);
        applyStimulus(3'd5, 1'b1, 1'b0, 12);
        checkOutput("entry_stage_ready", 32'(stage), 32'd3);
        checkOutput("entry_word", 32'(alu_word), 32'b011_010_101);
        checkOutput("entry_valid", 32'(word_valid), 32'd1);
        checkOutput("entry_load_pulses", 32'(load_count - load0), 32'd1);

        // Step out of READY keeps the fields
        applyStimulus(3'd7, 1'b1, 1'b0, 12);
        checkOutput("wrap_stage", 32'(stage), 32'd0);
        checkOutput("wrap_valid", 32'(word_valid), 32'd0);
        checkOutput("wrap_word", 32'(alu_word), 32'b011_010_101);

        // Illegal opcode refused, then a legal one
        rej0 = reject_count;
        applyStimulus(3'd6, 1'b1, 1'b0, 12);
        checkOutput("illegal_stage", 32'(stage), 32'd0);
        checkOutput("illegal_op_kept", 32'(alu_word[8:6]), 32'd3);
        checkOutput("illegal_reject_pulses", 32'(reject_count - rej0), 32'd1);
        applyStimulus(3'd4, 1'b1, 1'b0, 12);
        checkOutput("legal_stage", 32'(stage), 32'd1);
        checkOutput("legal_op", 32'(alu_word[8:6]), 32'd4);

        // Bouncing step key in LOAD_A: only the final long press counts
        sw_data = 3'd1;
        for (int r = 0; r < 5; r++) begin
            key_step_n = 1'b0;
            repeat (3) @(negedge clk);
            key_step_n = 1'b1;
            repeat (2) @(negedge clk);
        end
        checkOutput("bounce_no_event", 32'(stage), 32'd1);
        key_step_n = 1'b0;
        n = 0;
        while (stage != 2'd2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkRange("bounce_latency", n, 8, 9);
        repeat (110 - n) @(negedge clk);
        checkOutput("bounce_single_event", 32'(stage), 32'd2);
        checkOutput("bounce_a_field", 32'(alu_word[5:3]), 32'd1);
        key_step_n = 1'b1;
        repeat (12) @(negedge clk);

        // Coincident step and clear in LOAD_B: clear wins
        load0 = load_count;
        applyStimulus(3'd6, 1'b1, 1'b1, 12);
        checkOutput("clear_stage", 32'(stage), 32'd0);
        checkOutput("clear_word", 32'(alu_word), 32'd0);
        checkOutput("clear_valid", 32'(word_valid), 32'd0);
        checkOutput("clear_no_load", 32'(load_count - load0), 32'd0);

        // Reset in LOAD_A while the step key is mid-debounce
        applyStimulus(3'd2, 1'b1, 1'b0, 12);
        checkOutput("prereset_stage", 32'(stage), 32'd1);
        @(negedge clk);
        key_step_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset_word", 32'(alu_word), 32'd0);
        checkOutput("midreset_stage", 32'(stage), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (stage != 2'd1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkRange("postreset_latency", n, 8, 9);
        repeat (30) @(negedge clk);
        checkOutput("postreset_single_event", 32'(stage), 32'd1);
        checkOutput("postreset_op", 32'(alu_word[8:6]), 32'd2);
        key_step_n = 1'b1;
        repeat (12) @(negedge clk);

        run_done = 1'b1;
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
